// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package regfile_pkg;

    localparam int XW_DEF    = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [XW_DEF-1:0] reg_data_t;

    localparam reg_data_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: decode, optional write bypass (REGFILE_BYPASS_EN), x0 squash, hold register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic [XW-1:0]     mem [NREGS],
    input  logic [NREGS-1:0]  busy_vec,
`ifdef REGFILE_BYPASS_EN
    input  logic [NREGS-1:0]  wr_hit,
    input  logic [XW-1:0]     wr_val [NREGS],
    input  logic [NREGS-1:0]  rsv_hit,
`endif
    output logic [XW-1:0]     rd_data,
    output logic              rd_busy
);

    logic [XW-1:0] data_nxt;
    logic          busy_nxt;

    always_comb begin
        data_nxt = mem[rd_addr];
        busy_nxt = busy_vec[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // A same-cycle reserve keeps the pre-reserve busy instead of the write clear.
        if (wr_hit[rd_addr]) begin
            data_nxt = wr_val[rd_addr];
            busy_nxt = rsv_hit[rd_addr] ? busy_vec[rd_addr] : 1'b0;
        end
`endif
        if (rd_addr == '0) begin
            data_nxt = '0;
            busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a per-register busy scoreboard.
// Same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NR    = 2,
    parameter int NW    = 1,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR-1:0]    rd_en_ip,
    input  logic [NR*AW-1:0] rd_addr_ip,
    output logic [NR*XW-1:0] rd_data_op,
    output logic [NR-1:0]    rd_busy_op,
    input  logic [NW-1:0]    wr_en_ip,
    input  logic [NW*AW-1:0] wr_addr_ip,
    input  logic [NW*XW-1:0] wr_data_ip,
    input  logic             rsv_en_ip,
    input  logic [AW-1:0]    rsv_addr_ip
);

    logic [XW-1:0]    x_q [1:NREGS-1];
    logic [NREGS-1:1] busy_q;

    logic [XW-1:0]    mem_view [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic [NREGS-1:0] wr_hit;
    logic [XW-1:0]    wr_val [NREGS];
    logic [NREGS-1:0] rsv_hit;

    always_comb begin
        mem_view[0] = '0;
        for (int i = 1; i < NREGS; i++) mem_view[i] = x_q[i];
    end

    assign busy_vec = {busy_q, 1'b0};

    // Ports are scanned in ascending order so the highest index wins a collision.
    always_comb begin
        logic [AW-1:0] wa;
        wa = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
        end
        for (int p = 0; p < NW; p++) begin
            wa = wr_addr_ip[p*AW +: AW];
            if (wr_en_ip[p]) begin
                wr_hit[wa] = 1'b1;
                wr_val[wa] = wr_data_ip[p*XW +: XW];
            end
        end
        wr_hit[0] = 1'b0;
    end

    always_comb begin
        rsv_hit = '0;
        if (rsv_en_ip && rsv_addr_ip != '0) rsv_hit[rsv_addr_ip] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) x_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_hit[i]) x_q[i] <= wr_val[i];
                if (rsv_hit[i])     busy_q[i] <= 1'b1;
                else if (wr_hit[i]) busy_q[i] <= 1'b0;
            end
        end
    end

    for (genvar r = 0; r < NR; r++) begin : g_rd
        regfile_rd_port #(
            .XW    (XW),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en_ip[r]),
            .rd_addr  (rd_addr_ip[r*AW +: AW]),
            .mem      (mem_view),
            .busy_vec (busy_vec),
`ifdef REGFILE_BYPASS_EN
            .wr_hit   (wr_hit),
            .wr_val   (wr_val),
            .rsv_hit  (rsv_hit),
`endif
            .rd_data  (rd_data_op[r*XW +: XW]),
            .rd_busy  (rd_busy_op[r])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NR=2, NW=2): directed table, hand sequences, random vs model.
module tb_regfile_mp;

    localparam int XW = 32;
    localparam int NREGS = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 5;
    localparam int W = XW + 1;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    rd_en_ip;
    logic [NR*AW-1:0] rd_addr_ip;
    logic [NR*XW-1:0] rd_data_op;
    logic [NR-1:0]    rd_busy_op;
    logic [NW-1:0]    wr_en_ip;
    logic [NW*AW-1:0] wr_addr_ip;
    logic [NW*XW-1:0] wr_data_ip;
    logic             rsv_en_ip;
    logic [AW-1:0]    rsv_addr_ip;

    regfile_mp #(.XW(XW), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en_ip    (rd_en_ip),
        .rd_addr_ip  (rd_addr_ip),
        .rd_data_op  (rd_data_op),
        .rd_busy_op  (rd_busy_op),
        .wr_en_ip    (wr_en_ip),
        .wr_addr_ip  (wr_addr_ip),
        .wr_data_ip  (wr_data_ip),
        .rsv_en_ip   (rsv_en_ip),
        .rsv_addr_ip (rsv_addr_ip)
    );

    typedef struct {
        logic [1:0]  rd_en;
        logic [4:0]  ra0, ra1;
        logic [1:0]  wr_en;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rsv_en;
        logic [4:0]  rsv_a;
        logic [31:0] exp_d0;
        logic        exp_b0;
    } vec_t;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: architectural registers, busy bits, held outputs
    logic [31:0] m_x [NREGS];
    logic        m_busy [NREGS];
    logic [31:0] m_d [NR];
    logic        m_b [NR];

    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    bit bypass_mode;

    function automatic vec_t mk(input logic [1:0] rd_en, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] wr_en, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic rsv_en, input logic [4:0] rsv_a,
                                input logic [31:0] exp_d0, input logic exp_b0);
        vec_t v;
        v.rd_en = rd_en; v.ra0 = ra0; v.ra1 = ra1;
        v.wr_en = wr_en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rsv_en = rsv_en; v.rsv_a = rsv_a;
        v.exp_d0 = exp_d0; v.exp_b0 = exp_b0;
        return v;
    endfunction

    function automatic vec_t rd_only(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        return mk(en, a0, a1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_x[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int r = 0; r < NR; r++) begin
            m_d[r] = '0;
            m_b[r] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Applies the architectural rules for one clock edge and queues expected port outputs.
    task automatic model_step(input vec_t v);
        logic [4:0]  ra [NR];
        logic [4:0]  wa [NW];
        logic [31:0] wd [NW];
        logic [31:0] d;
        logic        b;
        ra[0] = v.ra0; ra[1] = v.ra1;
        wa[0] = v.wa0; wa[1] = v.wa1;
        wd[0] = v.wd0; wd[1] = v.wd1;
        for (int r = 0; r < NR; r++) begin
            if (v.rd_en[r]) begin
                d = m_x[ra[r]];
                b = m_busy[ra[r]];
                if (bypass_mode && ra[r] != 0) begin
                    for (int p = 0; p < NW; p++) begin
                        if (v.wr_en[p] && wa[p] == ra[r]) begin
                            d = wd[p];
                            b = (v.rsv_en && v.rsv_a == ra[r]) ? m_busy[ra[r]] : 1'b0;
                        end
                    end
                end
                m_d[r] = d;
                m_b[r] = b;
            end
            exp_q.push_back({m_b[r], m_d[r]});
        end
        for (int p = 0; p < NW; p++) begin
            if (v.wr_en[p] && wa[p] != 0) begin
                m_x[wa[p]] = wd[p];
                m_busy[wa[p]] = 1'b0;
            end
        end
        if (v.rsv_en && v.rsv_a != 0) m_busy[v.rsv_a] = 1'b1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy=%0b data=%08h, expected busy=%0b data=%08h",
                     name, act[XW], act[XW-1:0], exp[XW], exp[XW-1:0]);
        end
    endtask

    // driver: called at a negedge; returns at the following negedge after checking both ports
    task automatic step(input vec_t v, input string name);
        logic [W-1:0] e;
        rd_en_ip    = v.rd_en;
        rd_addr_ip  = {v.ra1, v.ra0};
        wr_en_ip    = v.wr_en;
        wr_addr_ip  = {v.wa1, v.wa0};
        wr_data_ip  = {v.wd1, v.wd0};
        rsv_en_ip   = v.rsv_en;
        rsv_addr_ip = v.rsv_a;
        model_step(v);
        @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            e = exp_q.pop_front();
            check($sformatf("%s port%0d", name, r), {rd_busy_op[r], rd_data_op[r*XW +: XW]}, e);
        end
    endtask

    task automatic idle_inputs();
        rd_en_ip = '0; rd_addr_ip = '0; wr_en_ip = '0; wr_addr_ip = '0;
        wr_data_ip = '0; rsv_en_ip = 1'b0; rsv_addr_ip = '0;
    endtask

    vec_t tbl [17];
    vec_t v;
    logic [31:0] last_x2;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass_mode = 1'b1;
`else
        bypass_mode = 1'b0;
`endif
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset port0", {rd_busy_op[0], rd_data_op[31:0]}, '0);
        check("reset port1", {rd_busy_op[1], rd_data_op[63:32]}, '0);
        rst_n = 1'b1;

        // every register reads zero and idle after reset
        for (int a = 0; a < NREGS; a++)
            step(rd_only(2'b11, 5'(a), 5'((a + 7) % NREGS)), $sformatf("reset sweep x%0d", a));

        tbl[0]  = rd_only(2'b01, 5'd0, 5'd0);
        tbl[1]  = mk(2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        tbl[2]  = mk(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0);
        tbl[3]  = mk(2'b00, 5'd0, 5'd0, 2'b01, 5'd0, 32'h1, 5'd0, 32'd0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0);
        tbl[4]  = rd_only(2'b01, 5'd0, 5'd0);
        tbl[5]  = mk(2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 1'b0);
        tbl[6]  = mk(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h22, 1'b0);
        tbl[7]  = mk(2'b01, 5'd3, 5'd0, 2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0,
                     bypass_mode ? 32'h55 : 32'h0, 1'b0);
        tbl[8]  = mk(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h55, 1'b0);
        tbl[9]  = mk(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0, 1'b0);
        tbl[10] = mk(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        tbl[11] = mk(2'b01, 5'd9, 5'd0, 2'b10, 5'd0, 32'd0, 5'd9, 32'hA5, 1'b0, 5'd0,
                     bypass_mode ? 32'hA5 : 32'h0, bypass_mode ? 1'b0 : 1'b1);
        tbl[12] = mk(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'hA5, 1'b0);
        tbl[13] = mk(2'b01, 5'd9, 5'd0, 2'b01, 5'd9, 32'h77, 5'd0, 32'd0, 1'b1, 5'd9,
                     bypass_mode ? 32'h77 : 32'hA5, 1'b0);
        tbl[14] = mk(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h77, 1'b1);
        tbl[15] = mk(2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0, 1'b0);
        tbl[16] = rd_only(2'b01, 5'd0, 5'd0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i], $sformatf("vec[%0d] model", i));
            check($sformatf("vec[%0d] table", i), {rd_busy_op[0], rd_data_op[31:0]},
                  {tbl[i].exp_b0, tbl[i].exp_d0});
        end

        // port 0 stalls for three cycles while x2 keeps changing
        step(rd_only(2'b01, 5'd2, 5'd0), "hold prime");
        check("hold prime x2", {rd_busy_op[0], rd_data_op[31:0]}, '0);
        last_x2 = '0;
        for (int k = 0; k < 3; k++) begin
            last_x2 = $urandom() | 32'h1;
            step(mk(2'b10, 5'd2, 5'd2, 2'b01, 5'd2, last_x2, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0),
                 $sformatf("hold cyc%0d", k));
            check($sformatf("hold cyc%0d port0", k), {rd_busy_op[0], rd_data_op[31:0]}, '0);
        end
        step(rd_only(2'b01, 5'd2, 5'd0), "hold release");
        check("hold release x2", {rd_busy_op[0], rd_data_op[31:0]}, {1'b0, last_x2});

        // random traffic, addresses mostly in a small window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            v.rd_en  = 2'($urandom_range(0, 3));
            v.ra0    = 5'($urandom_range(0, 7));
            v.ra1    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.wr_en  = 2'($urandom_range(0, 3));
            v.wa0    = 5'($urandom_range(0, 7));
            v.wa1    = 5'($urandom_range(0, 7));
            v.wd0    = $urandom();
            v.wd1    = $urandom();
            v.rsv_en = 1'($urandom_range(0, 1));
            v.rsv_a  = 5'($urandom_range(0, 7));
            v.exp_d0 = '0;
            v.exp_b0 = 1'b0;
            step(v, $sformatf("rand%0d", n));
        end

        // reset asserted between edges clears outputs without a clock
        step(mk(2'b00, 5'd0, 5'd0, 2'b01, 5'd1, 32'hCAFE, 5'd0, 32'd0, 1'b1, 5'd1, 32'd0, 1'b0), "pre-rst write");
        step(rd_only(2'b11, 5'd1, 5'd1), "pre-rst read");
        check("pre-rst x1", {rd_busy_op[0], rd_data_op[31:0]}, {1'b1, 32'hCAFE});
        wr_en_ip = 2'b01; wr_addr_ip = {5'd0, 5'd4}; wr_data_ip = {32'd0, 32'h1234};
        rsv_en_ip = 1'b1; rsv_addr_ip = 5'd4;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst port0", {rd_busy_op[0], rd_data_op[31:0]}, '0);
        check("async rst port1", {rd_busy_op[1], rd_data_op[63:32]}, '0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(rd_only(2'b11, 5'd1, 5'd4), "post-rst read");
        check("post-rst x1", {rd_busy_op[0], rd_data_op[31:0]}, '0);
        check("post-rst x4", {rd_busy_op[1], rd_data_op[63:32]}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
